voice_alloc: RTL

Polyphonic voice allocator. It sits between the key-event source (MIDI/keyboard decoder) and the multi-voice synth engine. It converts key press/release events into per-voice pitch, frequency, gate and trigger state. Allocation uses least-recently-allocated order, deduplicates same-pitch presses, and steals the oldest voice when every voice is gated. Voice state is snapshotted once per sample frame, so the engine sees stable parameters for a whole frame.

---
 rtl/voice_pkg.sv | 17 +
 rtl/voice_alloc_lru_rank.sv | 37 +++
 rtl/voice_alloc.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/voice_pkg.sv
// rtl/voice_pkg.sv - shared defaults and types for the polyphonic voice allocator
package voice_pkg;

    localparam int DEF_VOICES  = 4;
    localparam int DEF_PITCH_W = 6;
    localparam int DEF_FREQ_W  = 24;

    typedef logic [$clog2(DEF_VOICES)-1:0] rank_t;

    typedef struct packed {
        logic [DEF_PITCH_W-1:0] pitch;
        logic [DEF_FREQ_W-1:0]  freq;
        logic                   gate;
        logic                   trig_pend;
    } voice_t;

endpackage

// File: rtl/voice_alloc_lru_rank.sv
// rtl/voice_alloc_lru_rank.sv - least-recently-allocated rank permutation (0 = newest)
module lru_rank
    import voice_pkg::*;
#(
    parameter int VOICES = DEF_VOICES,
    parameter int RANK_W = $clog2(VOICES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          touch_en,
    input  logic [RANK_W-1:0]             touch_idx,
    output logic [VOICES-1:0][RANK_W-1:0] rank
);

    logic [RANK_W-1:0] touched_rank;

    assign touched_rank = rank[touch_idx];

    // Touched voice moves to the front; only voices newer than it age by one,
    // so the ranks remain a permutation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VOICES; i++) begin
                rank[i] <= RANK_W'(VOICES - 1 - i);
            end
        end else if (touch_en) begin
            for (int i = 0; i < VOICES; i++) begin
                if (RANK_W'(i) == touch_idx) begin
                    rank[i] <= '0;
                end else if (rank[i] < touched_rank) begin
                    rank[i] <= rank[i] + RANK_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// rtl/voice_alloc.sv - key events to per-voice pitch/freq/gate/trigger with frame snapshots
module voice_alloc
    import voice_pkg::*;
#(
    parameter int VOICES  = DEF_VOICES,
    parameter int PITCH_W = DEF_PITCH_W,
    parameter int FREQ_W  = DEF_FREQ_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           key_press,
    input  logic                           key_release,
    input  logic [PITCH_W-1:0]             pitch,
    input  logic [FREQ_W-1:0]              freq,
    input  logic                           frame_start,
    output logic [VOICES-1:0][PITCH_W-1:0] v_pitch,
    output logic [VOICES-1:0][FREQ_W-1:0]  v_freq,
    output logic [VOICES-1:0]              v_gate,
    output logic [VOICES-1:0]              v_trigger,
    output logic [$clog2(VOICES):0]        active_count,
    output logic                           steal,
    output logic                           drop
);

    localparam int IDX_W = $clog2(VOICES);
    localparam int CNT_W = IDX_W + 1;

    logic [VOICES-1:0][PITCH_W-1:0] live_pitch;
    logic [VOICES-1:0][FREQ_W-1:0]  live_freq;
    logic [VOICES-1:0]              live_gate;
    logic [VOICES-1:0]              live_trig;
    logic [VOICES-1:0][IDX_W-1:0]   rank;

    logic [VOICES-1:0] hit;
    logic              match_found;
    logic              free_found;
    logic              old_found;
    logic [IDX_W-1:0]  match_idx;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  free_rank;
    logic [IDX_W-1:0]  old_idx;
    logic [IDX_W-1:0]  old_rank;
    logic [IDX_W-1:0]  sel_idx;
    logic [VOICES-1:0] gate_nx;
    logic [VOICES-1:0] trig_nx;
    logic [CNT_W-1:0]  count_nx;
    logic              steal_nx;
    logic              drop_nx;

    lru_rank #(
        .VOICES (VOICES),
        .RANK_W (IDX_W)
    ) u_rank (
        .clk       (clk),
        .rst       (rst),
        .touch_en  (key_press),
        .touch_idx (sel_idx),
        .rank      (rank)
    );

    // Dedup keeps at most one gated voice per pitch, so any hit is the hit.
    always_comb begin
        hit         = '0;
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        free_rank   = '0;
        old_found   = 1'b0;
        old_idx     = '0;
        old_rank    = '0;
        for (int i = 0; i < VOICES; i++) begin
            hit[i] = live_gate[i] && (live_pitch[i] == pitch);
            if (hit[i]) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
            if (!live_gate[i] && (!free_found || rank[i] > free_rank)) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
                free_rank  = rank[i];
            end
            if (live_gate[i] && (!old_found || rank[i] > old_rank)) begin
                old_found = 1'b1;
                old_idx   = IDX_W'(i);
                old_rank  = rank[i];
            end
        end

        if (match_found) begin
            sel_idx = match_idx;
        end else if (free_found) begin
            sel_idx = free_idx;
        end else begin
            sel_idx = old_idx;
        end

        steal_nx = key_press && !match_found && !free_found;
        drop_nx  = key_press && key_release;
    end

    // A trigger set in the snapshot cycle must survive the clear of captured bits.
    always_comb begin
        gate_nx  = live_gate;
        trig_nx  = frame_start ? '0 : live_trig;
        count_nx = '0;
        if (key_press) begin
            gate_nx[sel_idx] = 1'b1;
            trig_nx[sel_idx] = 1'b1;
        end else if (key_release) begin
            gate_nx = live_gate & ~hit;
        end
        for (int i = 0; i < VOICES; i++) begin
            count_nx = count_nx + CNT_W'(gate_nx[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_pitch   <= '0;
            live_freq    <= '0;
            live_gate    <= '0;
            live_trig    <= '0;
            v_pitch      <= '0;
            v_freq       <= '0;
            v_gate       <= '0;
            v_trigger    <= '0;
            active_count <= '0;
            steal        <= 1'b0;
            drop         <= 1'b0;
        end else begin
            live_gate <= gate_nx;
            live_trig <= trig_nx;
            if (key_press) begin
                live_pitch[sel_idx] <= pitch;
                live_freq[sel_idx]  <= freq;
            end
            if (frame_start) begin
                v_pitch   <= live_pitch;
                v_freq    <= live_freq;
                v_gate    <= live_gate;
                v_trigger <= live_trig;
            end
            active_count <= count_nx;
            steal        <= steal_nx;
            drop         <= drop_nx;
        end
    end

endmodule
